// File: rtl/exec_stage_pkg.sv
// Shared encodings for the execute stage: ALU/compare opcodes, result select
// codes, and the bypass payload forwarded to MEM.
package exec_stage_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned MEM_OP_W   = 2;
   localparam int unsigned ALU_OP_W   = 4;
   localparam int unsigned CMP_OP_W   = 3;
   localparam int unsigned EX_OUT_W   = 2;
   localparam int unsigned SHAMT_W    = 5;

   localparam logic ENABLE    = 1'b1;
   localparam logic DISABLE   = 1'b0;
   localparam logic CMP_TRUE  = 1'b1;
   localparam logic CMP_FALSE = 1'b0;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_OP_NOP  = 4'd0,
      ALU_OP_AND  = 4'd1,
      ALU_OP_OR   = 4'd2,
      ALU_OP_XOR  = 4'd3,
      ALU_OP_ADD  = 4'd4,
      ALU_OP_SUB  = 4'd5,
      ALU_OP_SLL  = 4'd6,
      ALU_OP_SRL  = 4'd7,
      ALU_OP_SRA  = 4'd8,
      ALU_OP_SLT  = 4'd9,
      ALU_OP_SLTU = 4'd10
   } alu_op_e;

   typedef enum logic [CMP_OP_W-1:0] {
      CMP_OP_NOP = 3'd0,
      CMP_OP_EQ  = 3'd1,
      CMP_OP_NE  = 3'd2,
      CMP_OP_LT  = 3'd3,
      CMP_OP_GE  = 3'd4,
      CMP_OP_LTU = 3'd5,
      CMP_OP_GEU = 3'd6
   } cmp_op_e;

   typedef enum logic [EX_OUT_W-1:0] {
      EX_OUT_ALU = 2'd0,
      EX_OUT_CMP = 2'd1,
      EX_OUT_PCN = 2'd2
   } ex_out_sel_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dst_address;
      logic                  gpr_we_;
      logic [MEM_OP_W-1:0]   mem_op;
      logic [WORD_W-1:0]     mem_wr_data;
   } ex_bypass_t;

endpackage

// File: rtl/exec_stage_alu.sv
// 32-bit wrap-around ALU; unknown opcodes produce zero.
module alu
   import exec_stage_pkg::*;
(
   input  logic [WORD_W-1:0]   alu_in0,
   input  logic [WORD_W-1:0]   alu_in1,
   input  logic [ALU_OP_W-1:0] alu_op,
   output logic [WORD_W-1:0]   out
);

   logic [SHAMT_W-1:0] shamt;

   assign shamt = alu_in1[SHAMT_W-1:0];

   always_comb begin
      out = '0;
      case (alu_op_e'(alu_op))
         ALU_OP_AND:  out = alu_in0 & alu_in1;
         ALU_OP_OR:   out = alu_in0 | alu_in1;
         ALU_OP_XOR:  out = alu_in0 ^ alu_in1;
         ALU_OP_ADD:  out = alu_in0 + alu_in1;
         ALU_OP_SUB:  out = alu_in0 - alu_in1;
         ALU_OP_SLL:  out = alu_in0 << shamt;
         ALU_OP_SRL:  out = alu_in0 >> shamt;
         ALU_OP_SRA:  out = WORD_W'($signed(alu_in0) >>> shamt);
         ALU_OP_SLT:  out = WORD_W'($signed(alu_in0) < $signed(alu_in1));
         ALU_OP_SLTU: out = WORD_W'(alu_in0 < alu_in1);
         default:     out = '0;
      endcase
   end

endmodule

// File: rtl/exec_stage_cmp.sv
// Branch comparator; unknown opcodes and NOP evaluate false.
module cmp
   import exec_stage_pkg::*;
(
   input  logic [WORD_W-1:0]   cmp_in0,
   input  logic [WORD_W-1:0]   cmp_in1,
   input  logic [CMP_OP_W-1:0] cmp_op,
   output logic                out
);

   logic eq, lt_s, lt_u;

   assign eq   = (cmp_in0 == cmp_in1);
   assign lt_s = ($signed(cmp_in0) < $signed(cmp_in1));
   assign lt_u = (cmp_in0 < cmp_in1);

   always_comb begin
      out = CMP_FALSE;
      case (cmp_op_e'(cmp_op))
         CMP_OP_EQ:  out = eq;
         CMP_OP_NE:  out = ~eq;
         CMP_OP_LT:  out = lt_s;
         CMP_OP_GE:  out = ~lt_s;
         CMP_OP_LTU: out = lt_u;
         CMP_OP_GEU: out = ~lt_u;
         default:    out = CMP_FALSE;
      endcase
   end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: combinational ALU/compare/result-select/branch decision plus
// the ID->EX bypass registers feeding MEM and the forwarding network.
module exec_stage
   import exec_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_dst_address,
   input  logic                  id_gpr_we_,
   input  logic [MEM_OP_W-1:0]   id_mem_op,
   input  logic [WORD_W-1:0]     id_mem_wr_data,
   output logic [REG_ADDR_W-1:0] ex_dst_address,
   output logic                  ex_gpr_we_,
   output logic [MEM_OP_W-1:0]   ex_mem_op,
   output logic [WORD_W-1:0]     ex_mem_wr_data,
   input  logic [WORD_W-1:0]     alu_in0,
   input  logic [WORD_W-1:0]     alu_in1,
   input  logic [ALU_OP_W-1:0]   alu_op,
   input  logic [WORD_W-1:0]     cmp_in0,
   input  logic [WORD_W-1:0]     cmp_in1,
   input  logic [CMP_OP_W-1:0]   cmp_op,
   input  logic [EX_OUT_W-1:0]   ex_out_sel,
   output logic [WORD_W-1:0]     ex_out,
   input  logic [WORD_W-1:0]     pc_next,
   input  logic                  jump_en,
   input  logic                  branch_en,
   output logic [WORD_W-1:0]     pc_target,
   output logic                  branch
);

   logic [WORD_W-1:0] alu_out;
   logic              cmp_out;
   ex_bypass_t        bypass_d, bypass_q;

   alu u_alu (
      .alu_in0 (alu_in0),
      .alu_in1 (alu_in1),
      .alu_op  (alu_op),
      .out     (alu_out)
   );

   cmp u_cmp (
      .cmp_in0 (cmp_in0),
      .cmp_in1 (cmp_in1),
      .cmp_op  (cmp_op),
      .out     (cmp_out)
   );

   // Result select; the unused code yields zero.
   always_comb begin
      ex_out = '0;
      case (ex_out_sel_e'(ex_out_sel))
         EX_OUT_ALU: ex_out = alu_out;
         EX_OUT_CMP: ex_out = WORD_W'(cmp_out);
         EX_OUT_PCN: ex_out = pc_next;
         default:    ex_out = '0;
      endcase
   end

   assign pc_target = alu_out;
   assign branch    = jump_en | (branch_en & cmp_out);

   always_comb begin
      bypass_d             = '0;
      bypass_d.dst_address = id_dst_address;
      bypass_d.gpr_we_     = id_gpr_we_;
      bypass_d.mem_op      = id_mem_op;
      bypass_d.mem_wr_data = id_mem_wr_data;
   end

   // Reset clears every field, including the active-low write enable.
   always_ff @(posedge clk) begin
      if (rst) bypass_q <= '0;
      else     bypass_q <= bypass_d;
   end

   assign ex_dst_address = bypass_q.dst_address;
   assign ex_gpr_we_     = bypass_q.gpr_we_;
   assign ex_mem_op      = bypass_q.mem_op;
   assign ex_mem_wr_data = bypass_q.mem_wr_data;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: stimulus queues expected values tagged with
// the cycle they become visible; a negedge monitor pops and compares them.
module tb_exec_stage;
   import exec_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_dst_address;
   logic        id_gpr_we_;
   logic [1:0]  id_mem_op;
   logic [31:0] id_mem_wr_data;
   logic [4:0]  ex_dst_address;
   logic        ex_gpr_we_;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [31:0] alu_in0, alu_in1, cmp_in0, cmp_in1, pc_next;
   logic [3:0]  alu_op;
   logic [2:0]  cmp_op;
   logic [1:0]  ex_out_sel;
   logic [31:0] ex_out, pc_target;
   logic        jump_en, branch_en, branch;

   exec_stage dut (
      .clk(clk), .rst(rst),
      .id_dst_address(id_dst_address), .id_gpr_we_(id_gpr_we_),
      .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .ex_dst_address(ex_dst_address), .ex_gpr_we_(ex_gpr_we_),
      .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
      .cmp_in0(cmp_in0), .cmp_in1(cmp_in1), .cmp_op(cmp_op),
      .ex_out_sel(ex_out_sel), .ex_out(ex_out), .pc_next(pc_next),
      .jump_en(jump_en), .branch_en(branch_en),
      .pc_target(pc_target), .branch(branch)
   );

   always #5 clk = ~clk;

   typedef enum int { S_OUT, S_BR, S_TGT, S_DST, S_WE, S_OP, S_DATA } sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      logic [31:0] exp;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(sig_e s);
      case (s)
         S_OUT:  return ex_out;
         S_BR:   return 32'(branch);
         S_TGT:  return pc_target;
         S_DST:  return 32'(ex_dst_address);
         S_WE:   return 32'(ex_gpr_we_);
         S_OP:   return 32'(ex_mem_op);
         default: return ex_mem_wr_data;
      endcase
   endfunction

   // Monitor: compare every entry whose visibility cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         logic [31:0] a;
         e = sb.pop_front();
         a = actual(e.sig);
         n_tests++;
         if (a !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
         end
      end
   end

   task automatic expect_now(string name, sig_e s, logic [31:0] v);
      sb.push_back('{name, s, v, cyc});
   endtask

   task automatic expect_next(string name, sig_e s, logic [31:0] v);
      sb.push_back('{name, s, v, cyc + 1});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_vec(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp);
      next_cycle();
      alu_op = op; alu_in0 = a; alu_in1 = b; ex_out_sel = 2'd0;
      jump_en = 1'b0; branch_en = 1'b0;
      expect_now({name, "/out"}, S_OUT, exp);
      expect_now({name, "/tgt"}, S_TGT, exp);
   endtask

   task automatic cmp_vec(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                          logic jen, logic ben, logic exp_cmp, logic exp_br);
      next_cycle();
      cmp_op = op; cmp_in0 = a; cmp_in1 = b; ex_out_sel = 2'd1;
      jump_en = jen; branch_en = ben;
      expect_now({name, "/out"}, S_OUT, 32'(exp_cmp));
      expect_now({name, "/br"}, S_BR, 32'(exp_br));
   endtask

   task automatic byp_vec(string name, logic r, logic [4:0] d, logic we, logic [1:0] op,
                          logic [31:0] data, logic [4:0] ed, logic ewe, logic [1:0] eop,
                          logic [31:0] edata);
      next_cycle();
      rst = r; id_dst_address = d; id_gpr_we_ = we; id_mem_op = op; id_mem_wr_data = data;
      expect_next({name, "/dst"}, S_DST, 32'(ed));
      expect_next({name, "/we"}, S_WE, 32'(ewe));
      expect_next({name, "/op"}, S_OP, 32'(eop));
      expect_next({name, "/data"}, S_DATA, edata);
   endtask

   initial begin
      rst = 1'b1;
      id_dst_address = 5'h1F; id_gpr_we_ = 1'b1; id_mem_op = 2'b11; id_mem_wr_data = '1;
      alu_in0 = '0; alu_in1 = '0; alu_op = '0; cmp_in0 = '0; cmp_in1 = '0; cmp_op = '0;
      ex_out_sel = '0; pc_next = '0; jump_en = 1'b0; branch_en = 1'b0;

      // Reset state observed after the first edge with rst high.
      byp_vec("reset", 1'b1, 5'h1F, 1'b1, 2'b11, 32'hFFFF_FFFF, 5'h0, 1'b0, 2'b00, 32'h0);
      next_cycle();
      rst = 1'b0;

      alu_vec("and",   4'd1,  32'h0,          32'hFF0,        32'h0);
      alu_vec("add1",  4'd4,  32'h00F0_0000,  32'h0F00_0000,  32'h0FF0_0000);
      alu_vec("add2",  4'd4,  32'h0,          32'hFF0,        32'hFF0);
      alu_vec("sub",   4'd5,  32'h0,          32'h1,          32'hFFFF_FFFF);
      alu_vec("sll",   4'd6,  32'h1,          32'h3F,         32'h8000_0000);
      alu_vec("srl",   4'd7,  32'h8000_0000,  32'h4,          32'h0800_0000);
      alu_vec("sra",   4'd8,  32'h8000_0000,  32'h4,          32'hF800_0000);
      alu_vec("slt",   4'd9,  32'hFFFF_FFFF,  32'h1,          32'h1);
      alu_vec("sltu",  4'd10, 32'hFFFF_FFFF,  32'h1,          32'h0);
      alu_vec("xor",   4'd3,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0);
      alu_vec("badop", 4'd15, 32'h1234_5678,  32'h1,          32'h0);

      cmp_vec("cmp_eq",   3'd1, 32'h0,         32'hFF0,        1'b0, 1'b0, 1'b0, 1'b0);
      cmp_vec("cmp_ne",   3'd2, 32'h0,         32'hFF0,        1'b0, 1'b0, 1'b1, 1'b0);
      cmp_vec("cmp_ge",   3'd4, 32'h0,         32'hFF0,        1'b0, 1'b0, 1'b0, 1'b0);
      cmp_vec("cmp_ges",  3'd4, 32'h0,         32'h8000_0FF0,  1'b0, 1'b0, 1'b1, 1'b0);
      cmp_vec("cmp_ltu",  3'd5, 32'h0,         32'h8000_0FF0,  1'b0, 1'b0, 1'b1, 1'b0);
      cmp_vec("cmp_bad",  3'd7, 32'h5,         32'h5,          1'b0, 1'b1, 1'b0, 1'b0);
      cmp_vec("nb_eq0",   3'd1, 32'h0,         32'h0,          1'b0, 1'b0, 1'b1, 1'b0);
      cmp_vec("nb_eq1k",  3'd1, 32'h1000,      32'h1000,       1'b0, 1'b0, 1'b1, 1'b0);
      cmp_vec("nb_ne",    3'd2, 32'h1000,      32'h1000,       1'b0, 1'b0, 1'b0, 1'b0);
      cmp_vec("br_eq",    3'd1, 32'h0,         32'h0,          1'b0, 1'b1, 1'b1, 1'b1);
      cmp_vec("br_ne",    3'd2, 32'h0,         32'h0,          1'b0, 1'b1, 1'b0, 1'b0);
      cmp_vec("br_ge",    3'd4, 32'h0,         32'h0,          1'b0, 1'b1, 1'b1, 1'b1);
      cmp_vec("br_gen",   3'd4, 32'h8000_0000, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0);
      cmp_vec("jmp",      3'd1, 32'hFDCC_0000, 32'h123,        1'b1, 1'b0, 1'b0, 1'b1);

      // Jump target is the ALU sum even while the result mux shows the link value.
      next_cycle();
      alu_op = 4'd4; alu_in0 = 32'h100; alu_in1 = 32'h20;
      ex_out_sel = 2'd2; pc_next = 32'h104; jump_en = 1'b1;
      expect_now("jmp_tgt", S_TGT, 32'h120);
      expect_now("jmp_lnk", S_OUT, 32'h104);
      expect_now("jmp_br",  S_BR,  32'h1);

      foreach (pc_next[i]) begin end
      begin
         logic [31:0] pcs [4] = '{32'h0, 32'h8000_0000, 32'h55AA_AA55, 32'hA0F0_00A0};
         for (int i = 0; i < 4; i++) begin
            next_cycle();
            jump_en = 1'b0; ex_out_sel = 2'd2; pc_next = pcs[i];
            expect_now($sformatf("pcn%0d", i), S_OUT, pcs[i]);
         end
      end
      next_cycle();
      ex_out_sel = 2'd3;
      expect_now("sel3", S_OUT, 32'h0);

      byp_vec("byp_rst",  1'b1, 5'h1F, 1'b1, 2'b11, 32'hFFFF_FFFF, 5'h00, 1'b0, 2'b00, 32'h0);
      byp_vec("byp_ones", 1'b0, 5'h1F, 1'b1, 2'b11, 32'hFFFF_FFFF, 5'h1F, 1'b1, 2'b11, 32'hFFFF_FFFF);
      byp_vec("byp_val",  1'b0, 5'h0F, 1'b0, 2'b01, 32'h12DF_0010, 5'h0F, 1'b0, 2'b01, 32'h12DF_0010);
      byp_vec("byp_mid",  1'b1, 5'h15, 1'b1, 2'b10, 32'hCAFE_F00D, 5'h00, 1'b0, 2'b00, 32'h0);
      byp_vec("byp_res",  1'b0, 5'h15, 1'b1, 2'b10, 32'hCAFE_F00D, 5'h15, 1'b1, 2'b10, 32'hCAFE_F00D);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb.size() > 0; i++) next_cycle();
      next_cycle();
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
